sha256_compress_ctrl: RTL

- Sequencer for the SHA-256 compression datapath: accepts one 512-bit message block as 16 streamed 32-bit words and runs 64 rounds at one round per cycle.
- Keeps working variables a..h, the 16-word message schedule window and the chaining hash H0..H7.
- Round logic uses the team's Ma/Ch/Σ0/Σ1/σ0/σ1 combinational functions and an internal 64-entry K constant table.
- Sits between the padding/word-feeder front end and the digest output register.

---
 rtl/sha256_compress_ctrl.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/sha256_compress_ctrl.sv
// SHA-256 compression sequencer. It takes one 512-bit block as 16 streamed
// 32-bit words, runs the rounds at one per cycle, then folds the working
// variables into the chaining hash.
module sha256_compress_ctrl #(
  parameter int unsigned NUM_ROUNDS = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         init,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [31:0]  in_word,
  output logic         out_valid,
  output logic         busy,
  output logic [255:0] digest
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_ROUND,
    S_FINAL
  } state_e;

  localparam logic [0:7][31:0] IV = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  localparam logic [0:63][31:0] K = {
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  localparam logic [5:0] LAST_T = 6'(NUM_ROUNDS - 1);

  function automatic logic [31:0] rotr(input logic [31:0] x, input int unsigned n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] big_sigma0(input logic [31:0] x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction

  function automatic logic [31:0] big_sigma1(input logic [31:0] x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction

  function automatic logic [31:0] small_sigma0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] small_sigma1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  function automatic logic [31:0] ch(input logic [31:0] e, input logic [31:0] f,
                                     input logic [31:0] g);
    return (e & f) ^ (~e & g);
  endfunction

  function automatic logic [31:0] maj(input logic [31:0] a, input logic [31:0] b,
                                      input logic [31:0] c);
    return (a & b) ^ (a & c) ^ (b & c);
  endfunction

  state_e            state_q, state_d;
  logic [0:7][31:0]  hash_q, hash_d;   // H0..H7
  logic [0:7][31:0]  wv_q, wv_d;       // a..h
  logic [0:15][31:0] w_q, w_d;         // slot 0 oldest, slot 15 newest
  logic [4:0]        cnt_q, cnt_d;
  logic [5:0]        t_q, t_d;
  logic              out_valid_q, out_valid_d;

  logic [31:0] t1;
  logic [31:0] t2;
  logic [31:0] w_next;

  // Round datapath: slot 0 holds W[t], so the window taps are W[t+1], W[t+9], W[t+14].
  always_comb begin
    t1     = wv_q[7] + big_sigma1(wv_q[4]) + ch(wv_q[4], wv_q[5], wv_q[6])
           + K[t_q] + w_q[0];
    t2     = big_sigma0(wv_q[0]) + maj(wv_q[0], wv_q[1], wv_q[2]);
    w_next = small_sigma1(w_q[14]) + w_q[9] + small_sigma0(w_q[1]) + w_q[0];
  end

  // Next-state, word intake, round update and chaining fold.
  always_comb begin
    state_d     = state_q;
    hash_d      = hash_q;
    wv_d        = wv_q;
    w_d         = w_q;
    cnt_d       = cnt_q;
    t_d         = t_q;
    out_valid_d = 1'b0;
    in_ready    = 1'b0;

    case (state_q)
      S_IDLE: begin
        in_ready = !init;
        if (init) begin
          hash_d = IV;
        end else if (in_valid) begin
          w_d     = {w_q[1:15], in_word};
          cnt_d   = 5'd1;
          wv_d    = hash_q;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        in_ready = 1'b1;
        if (in_valid) begin
          w_d   = {w_q[1:15], in_word};
          cnt_d = cnt_q + 5'd1;
          if (cnt_q == 5'd15) begin
            t_d     = '0;
            state_d = S_ROUND;
          end
        end
      end
      S_ROUND: begin
        wv_d = {t1 + t2, wv_q[0:2], wv_q[3] + t1, wv_q[4:6]};
        w_d  = {w_q[1:15], w_next};
        t_d  = t_q + 6'd1;
        if (t_q == LAST_T) begin
          state_d = S_FINAL;
        end
      end
      S_FINAL: begin
        for (int unsigned i = 0; i < 8; i++) begin
          hash_d[i] = hash_q[i] + wv_q[i];
        end
        out_valid_d = 1'b1;
        state_d     = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State registers with synchronous reset; reset restores the IV and drops any partial block.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      hash_q      <= IV;
      wv_q        <= '0;
      w_q         <= '0;
      cnt_q       <= '0;
      t_q         <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      hash_q      <= hash_d;
      wv_q        <= wv_d;
      w_q         <= w_d;
      cnt_q       <= cnt_d;
      t_q         <= t_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_valid = out_valid_q;
  assign busy      = (state_q != S_IDLE);
  assign digest    = hash_q;

endmodule
